// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide coprocessor owning the HI/LO pair.
// One radix-2 Booth step or one restoring-division step per clock, 32 steps per op.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    // acc carries one guard bit so Booth subtraction of -2^(W-1) cannot overflow
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic             q_1;
    logic [WIDTH-1:0] opnd;
    logic             sign_a, sign_b;

    logic             start_mult, start_div, start_div_zero, last_step;
    logic [WIDTH:0]   booth_sum, acc_step;
    logic [WIDTH-1:0] mq_step;
    logic [WIDTH:0]   rem_shift, rem_diff, div_rem_step;
    logic [WIDTH-1:0] div_quo_step, quot_fin, rem_fin;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next     = state;
        start_mult     = (state == IDLE) && mult_start;
        start_div      = (state == IDLE) && !mult_start && div_start && (B != '0);
        start_div_zero = (state == IDLE) && !mult_start && div_start && (B == '0);
        last_step      = (count == CW'(WIDTH - 1));

        case ({mq[0], q_1})
            2'b01:   booth_sum = acc + {opnd[WIDTH-1], opnd};
            2'b10:   booth_sum = acc - {opnd[WIDTH-1], opnd};
            default: booth_sum = acc;
        endcase
        acc_step = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mq_step  = {booth_sum[0], mq[WIDTH-1:1]};

        rem_shift    = {acc[WIDTH-1:0], mq[WIDTH-1]};
        rem_diff     = rem_shift - {1'b0, opnd};
        div_rem_step = rem_diff[WIDTH] ? rem_shift : rem_diff;
        div_quo_step = {mq[WIDTH-2:0], ~rem_diff[WIDTH]};
        quot_fin     = (sign_a ^ sign_b) ? -div_quo_step : div_quo_step;
        rem_fin      = sign_a ? -div_rem_step[WIDTH-1:0] : div_rem_step[WIDTH-1:0];

        case (state)
            IDLE: begin
                if (start_mult)     state_next = MULT;
                else if (start_div) state_next = DIV;
            end
            MULT:    if (last_step) state_next = IDLE;
            DIV:     if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            acc      <= '0;
            mq       <= '0;
            q_1      <= 1'b0;
            opnd     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            HI       <= '0;
            LO       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        acc   <= '0;
                        mq    <= B;
                        q_1   <= 1'b0;
                        opnd  <= A;
                        count <= '0;
                        busy  <= 1'b1;
                    end else if (start_div) begin
                        // Divide runs on magnitudes; signs are reapplied at the last step
                        acc    <= '0;
                        mq     <= A[WIDTH-1] ? -A : A;
                        opnd   <= B[WIDTH-1] ? -B : B;
                        sign_a <= A[WIDTH-1];
                        sign_b <= B[WIDTH-1];
                        count  <= '0;
                        busy   <= 1'b1;
                    end else if (start_div_zero) begin
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                    end
                end
                MULT: begin
                    acc   <= acc_step;
                    mq    <= mq_step;
                    q_1   <= mq[0];
                    count <= count + 1'b1;
                    if (last_step) begin
                        HI   <= acc_step[WIDTH-1:0];
                        LO   <= mq_step;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                DIV: begin
                    acc   <= div_rem_step;
                    mq    <= div_quo_step;
                    count <= count + 1'b1;
                    if (last_step) begin
                        LO   <= quot_fin;
                        HI   <= rem_fin;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: latency, results, arbitration,
// ignored starts, divide-by-zero and mid-operation reset.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start, div_start;
    logic [31:0] A, B;
    logic [31:0] HI, LO;
    logic        busy, done, div_zero;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .A          (A),
        .B          (B),
        .HI         (HI),
        .LO         (LO),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a start at edge 0; returns #1 into cycle 1.
    task automatic start_op(input logic ms, input logic ds, input logic [31:0] a, input logic [31:0] b);
        mult_start = ms;
        div_start  = ds;
        A          = a;
        B          = b;
        @(posedge clk); #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
    endtask

    // Walk cycles from 1 until done (bounded), optionally pulsing div_start or
    // changing A/B at a given cycle; returns #1 into the done cycle.
    task automatic wait_done(input int div_at, input int ab_at,
                             output int done_c, output int busy_c);
        int c = 1;
        done_c = -1;
        busy_c = 0;
        while (c <= 40 && done_c < 0) begin
            if (done) begin
                done_c = c;
            end else begin
                if (busy) busy_c++;
                div_start = (c == div_at);
                if (c == ab_at) begin
                    A = 32'hDEAD_BEEF;
                    B = 32'h1234_5678;
                end
                @(posedge clk); #1;
                div_start = 1'b0;
                c++;
            end
        end
    endtask

    task automatic idle_cycles(input int n, output int done_cnt, output int busy_cnt);
        done_cnt = 0;
        busy_cnt = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
    endtask

    initial begin
        int dc, bc, nd, nb;
        reset      = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        A          = '0;
        B          = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", HI, 32'h0);
        check("rst_lo", LO, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_dz", {31'b0, div_zero}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: 7 * -3
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done(-1, -1, dc, bc);
        check("t1_done_cycle", 32'(dc), 32'd33);
        check("t1_busy_cycles", 32'(bc), 32'd32);
        check("t1_busy_at_done", {31'b0, busy}, 32'h0);
        check("t1_hi", HI, 32'hFFFF_FFFF);
        check("t1_lo", LO, 32'hFFFF_FFEB);
        idle_cycles(1, nd, nb);
        check("t1_done_one_cycle", 32'(nd), 32'd0);

        // 2: most-negative squared, then back-to-back divide 100/7
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(-1, -1, dc, bc);
        check("t2_hi", HI, 32'h4000_0000);
        check("t2_lo", LO, 32'h0000_0000);
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        check("t2_div_busy", {31'b0, busy}, 32'h1);
        wait_done(-1, -1, dc, bc);
        check("t2_div_done_cycle", 32'(dc), 32'd33);
        check("t2_div_lo", LO, 32'd14);
        check("t2_div_hi", HI, 32'd2);

        // 3: -7 / 2
        start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(-1, -1, dc, bc);
        check("t3_lo", LO, 32'hFFFF_FFFD);
        check("t3_hi", HI, 32'hFFFF_FFFF);
        check("t3_dz", {31'b0, div_zero}, 32'h0);

        // 4: preload HI/LO=0x11/0x22, divide by zero, then -2^31 / -1
        start_op(1'b1, 1'b0, 32'h66, 32'h2AAA_AAAB);
        wait_done(-1, -1, dc, bc);
        check("t4_pre_hi", HI, 32'h11);
        check("t4_pre_lo", LO, 32'h22);
        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        check("t4_dz_done", {31'b0, done}, 32'h1);
        check("t4_dz_flag", {31'b0, div_zero}, 32'h1);
        check("t4_dz_busy", {31'b0, busy}, 32'h0);
        check("t4_dz_hi", HI, 32'h11);
        check("t4_dz_lo", LO, 32'h22);
        idle_cycles(1, nd, nb);
        check("t4_dz_done_clr", {31'b0, done}, 32'h0);
        check("t4_dz_flag_clr", {31'b0, div_zero}, 32'h0);
        check("t4_dz_busy_after", 32'(nb), 32'd0);
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(-1, -1, dc, bc);
        check("t4_ovf_lo", LO, 32'h8000_0000);
        check("t4_ovf_hi", HI, 32'h0);
        check("t4_ovf_dz", {31'b0, div_zero}, 32'h0);

        // 5: both starts -> multiply; then ignored div_start and operand change mid-op
        start_op(1'b1, 1'b1, 32'd6, 32'd3);
        wait_done(-1, -1, dc, bc);
        check("t5_arb_lo", LO, 32'd18);
        check("t5_arb_hi", HI, 32'd0);
        start_op(1'b1, 1'b0, 32'd1000, 32'hFFFF_FFFD);
        wait_done(10, 5, dc, bc);
        check("t5_done_cycle", 32'(dc), 32'd33);
        check("t5_lo", LO, 32'hFFFF_F448);
        check("t5_hi", HI, 32'hFFFF_FFFF);
        idle_cycles(40, nd, nb);
        check("t5_extra_done", 32'(nd), 32'd0);
        check("t5_extra_busy", 32'(nb), 32'd0);

        // 6: reset in cycle 15 of a multiply
        start_op(1'b1, 1'b0, 32'h1234, 32'h5678);
        repeat (14) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t6_rst_hi", HI, 32'h0);
        check("t6_rst_lo", LO, 32'h0);
        check("t6_rst_busy", {31'b0, busy}, 32'h0);
        check("t6_rst_done", {31'b0, done}, 32'h0);
        idle_cycles(40, nd, nb);
        check("t6_no_done", 32'(nd), 32'd0);
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        wait_done(-1, -1, dc, bc);
        check("t6_done_cycle", 32'(dc), 32'd33);
        check("t6_lo", LO, 32'd12);
        check("t6_hi", HI, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
